// File: rtl/dsp_share_if.sv
// Bundle of all handshake and DSP-side signals around dsp_share_arbiter.
//   slave  : the arbiter's view (takes requests, drives responses and the DSP)
//   master : the environment's view (requesters plus the DSP slice)
// Signals:
//   reqN_valid_i/op_i/a_i/b_i  requester N operation offer
//   reqN_ready_o               requester N offer taken this cycle
//   rspN_valid_o/result_o/err_o requester N response pulse and held result
//   dsp_op_o/a_o/b_o/start_o   launch side of the shared DSP slice
//   dsp_result_i               DSP result, valid DSP_LATENCY cycles after start
interface dsp_share_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int OP_WIDTH     = 3
);
  logic                    req0_valid_i;
  logic                    req0_ready_o;
  logic [OP_WIDTH-1:0]     req0_op_i;
  logic [DATA_WIDTH-1:0]   req0_a_i;
  logic [DATA_WIDTH-1:0]   req0_b_i;
  logic                    rsp0_valid_o;
  logic [RESULT_WIDTH-1:0] rsp0_result_o;
  logic                    rsp0_err_o;

  logic                    req1_valid_i;
  logic                    req1_ready_o;
  logic [OP_WIDTH-1:0]     req1_op_i;
  logic [DATA_WIDTH-1:0]   req1_a_i;
  logic [DATA_WIDTH-1:0]   req1_b_i;
  logic                    rsp1_valid_o;
  logic [RESULT_WIDTH-1:0] rsp1_result_o;
  logic                    rsp1_err_o;

  logic [OP_WIDTH-1:0]     dsp_op_o;
  logic [DATA_WIDTH-1:0]   dsp_a_o;
  logic [DATA_WIDTH-1:0]   dsp_b_o;
  logic                    dsp_start_o;
  logic [RESULT_WIDTH-1:0] dsp_result_i;
  logic                    busy_o;

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_err_o,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_err_o,
    output dsp_op_o, dsp_a_o, dsp_b_o, dsp_start_o, busy_o,
    input  dsp_result_i
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_err_o,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_err_o,
    input  dsp_op_o, dsp_a_o, dsp_b_o, dsp_start_o, busy_o,
    output dsp_result_i
  );
endinterface

// File: rtl/dsp_share_arbiter.sv
// Round-robin sharing of one pipelined DSP slice between two requesters.
// One op is accepted in IDLE, launched (ISSUE), waited on for DSP_LATENCY
// cycles (WAIT) and its result returned as a one-cycle pulse (RESP) to the
// requester that issued it. Illegal op codes skip the DSP and respond with
// result 0 / err 1 one cycle after acceptance.
// Ports:
//   clk_i    clock (clk_100 domain)
//   reset_i  synchronous, active-high reset
//   bus      dsp_share_if.slave: requester handshakes, responses, DSP side
module dsp_share_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int OP_WIDTH     = 3,
  parameter int DSP_LATENCY  = 3,
  parameter int NUM_OPS      = 6
) (
  input  logic        clk_i,
  input  logic        reset_i,
  dsp_share_if.slave  bus
);

  localparam int CNT_W = (DSP_LATENCY < 2) ? 1 : $clog2(DSP_LATENCY + 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(DSP_LATENCY);
  // One extra bit so NUM_OPS == 2**OP_WIDTH still compares correctly.
  localparam logic [OP_WIDTH:0] OP_LIMIT = (OP_WIDTH + 1)'(NUM_OPS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic                    last_grant_reg;
  logic                    owner_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [OP_WIDTH-1:0]     dsp_op_reg;
  logic [DATA_WIDTH-1:0]   dsp_a_reg;
  logic [DATA_WIDTH-1:0]   dsp_b_reg;
  logic                    dsp_start_reg;

  logic                    grant;
  logic                    ready0, ready1, accept;
  logic [OP_WIDTH-1:0]     sel_op;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b;
  logic                    sel_legal;
  logic                    illegal_take;
  logic                    capture;

  // Arbitration and next state. A lone requester always wins; on contention
  // the one that did not win last time goes first.
  always_comb begin
    grant      = ~last_grant_reg;
    if (bus.req0_valid_i && !bus.req1_valid_i) begin
      grant = 1'b0;
    end else if (bus.req1_valid_i && !bus.req0_valid_i) begin
      grant = 1'b1;
    end
    ready0       = (state_reg == IDLE) && bus.req0_valid_i && !grant;
    ready1       = (state_reg == IDLE) && bus.req1_valid_i && grant;
    accept       = ready0 || ready1;
    sel_op       = grant ? bus.req1_op_i : bus.req0_op_i;
    sel_a        = grant ? bus.req1_a_i  : bus.req0_a_i;
    sel_b        = grant ? bus.req1_b_i  : bus.req0_b_i;
    sel_legal    = ({1'b0, sel_op} < OP_LIMIT);
    illegal_take = accept && !sel_legal;
    capture      = (state_reg == WAIT) && (cnt_reg == CNT_W'(1));

    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = sel_legal ? ISSUE : RESP;
      ISSUE: state_next = WAIT;
      WAIT:  if (capture) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Launch-side datapath. The DSP operands are loaded on the accept edge so
  // they are already valid during the ISSUE cycle alongside the start strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      cnt_reg        <= '0;
      dsp_op_reg     <= '0;
      dsp_a_reg      <= '0;
      dsp_b_reg      <= '0;
      dsp_start_reg  <= 1'b0;
    end else begin
      dsp_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg      <= grant;
            last_grant_reg <= grant;
            if (sel_legal) begin
              dsp_op_reg    <= sel_op;
              dsp_a_reg     <= sel_a;
              dsp_b_reg     <= sel_b;
              dsp_start_reg <= 1'b1;
            end
          end
        end
        ISSUE:   cnt_reg <= LAT_LOAD;
        WAIT:    cnt_reg <= cnt_reg - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Per-requester response registers; only the owner of the completing op
  // is touched, the other requester keeps its last result.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic                    valid_reg;
    logic [RESULT_WIDTH-1:0] result_reg;
    logic                    err_reg;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        valid_reg  <= 1'b0;
        result_reg <= '0;
        err_reg    <= 1'b0;
      end else begin
        valid_reg <= 1'b0;
        if (illegal_take && (grant == 1'(gi))) begin
          valid_reg  <= 1'b1;
          result_reg <= '0;
          err_reg    <= 1'b1;
        end else if (capture && (owner_reg == 1'(gi))) begin
          valid_reg  <= 1'b1;
          result_reg <= bus.dsp_result_i;
          err_reg    <= 1'b0;
        end
      end
    end
  end

  assign bus.req0_ready_o  = ready0;
  assign bus.req1_ready_o  = ready1;
  assign bus.rsp0_valid_o  = g_rsp[0].valid_reg;
  assign bus.rsp0_result_o = g_rsp[0].result_reg;
  assign bus.rsp0_err_o    = g_rsp[0].err_reg;
  assign bus.rsp1_valid_o  = g_rsp[1].valid_reg;
  assign bus.rsp1_result_o = g_rsp[1].result_reg;
  assign bus.rsp1_err_o    = g_rsp[1].err_reg;
  assign bus.dsp_op_o      = dsp_op_reg;
  assign bus.dsp_a_o       = dsp_a_reg;
  assign bus.dsp_b_o       = dsp_b_reg;
  assign bus.dsp_start_o   = dsp_start_reg;
  assign bus.busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_dsp_share_arbiter.sv
module tb_dsp_share_arbiter;
  localparam int DW  = 8;
  localparam int RW  = 16;
  localparam int OW  = 3;
  localparam int LAT = 3;

  logic clk;
  logic reset_i;
  logic mul_mode;
  int   checks;
  int   failures;

  dsp_share_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .OP_WIDTH(OW)) bus ();

  dsp_share_arbiter #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .OP_WIDTH(OW),
    .DSP_LATENCY(LAT), .NUM_OPS(6)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP model: the result is only meaningful exactly LAT cycles after the
  // start cycle; any other cycle shows a junk value.
  logic [LAT-1:0] start_sr;
  always @(posedge clk) begin
    if (reset_i) start_sr <= '0;
    else         start_sr <= {start_sr[LAT-2:0], bus.dsp_start_o};
  end
  assign bus.dsp_result_i = start_sr[LAT-1]
    ? (mul_mode ? RW'(bus.dsp_a_o) * RW'(bus.dsp_b_o) : RW'(bus.dsp_a_o) + RW'(bus.dsp_b_o))
    : 16'hDEAD;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid_i = 1'b0; bus.req0_op_i = '0; bus.req0_a_i = '0; bus.req0_b_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_op_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0;
  endtask

  // Leaves the bench 1 time unit into cycle 0, with the DUT freshly in IDLE.
  task automatic do_reset();
    reset_i = 1'b1;
    clear_inputs();
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.dsp_start_o !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.dsp_start_o); end
    checks++; if (bus.dsp_a_o !== 8'd0 || bus.dsp_b_o !== 8'd0 || bus.dsp_op_o !== 3'd0) begin
      failures++; $display("FAIL reset_dsp a=%0d b=%0d op=%0d exp=0", bus.dsp_a_o, bus.dsp_b_o, bus.dsp_op_o); end
    checks++; if ({bus.rsp0_valid_o, bus.rsp0_err_o, bus.rsp1_valid_o, bus.rsp1_err_o} !== 4'b0) begin
      failures++; $display("FAIL reset_rsp_flags got=%b exp=0000", {bus.rsp0_valid_o, bus.rsp0_err_o, bus.rsp1_valid_o, bus.rsp1_err_o}); end
    checks++; if (bus.rsp0_result_o !== 16'd0 || bus.rsp1_result_o !== 16'd0) begin
      failures++; $display("FAIL reset_rsp_result r0=%0d r1=%0d exp=0", bus.rsp0_result_o, bus.rsp1_result_o); end
    $display("test_reset done");
  endtask

  task automatic test_single_add();
    do_reset();
    mul_mode = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 3'd0; bus.req0_a_i = 8'd5; bus.req0_b_i = 8'd7;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1) begin failures++; $display("FAIL add_ready0 got=%b exp=1", bus.req0_ready_o); end
    for (int c = 1; c <= 6; c++) begin
      step();
      bus.req0_valid_i = 1'b0;
      #1;
      checks++; if (bus.dsp_start_o !== (c == 1)) begin failures++; $display("FAIL add_start cyc=%0d got=%b exp=%b", c, bus.dsp_start_o, (c == 1)); end
      checks++; if (bus.dsp_a_o !== 8'd5 || bus.dsp_b_o !== 8'd7) begin failures++; $display("FAIL add_operands cyc=%0d got=%0d,%0d exp=5,7", c, bus.dsp_a_o, bus.dsp_b_o); end
      checks++; if (bus.rsp0_valid_o !== (c == 5)) begin failures++; $display("FAIL add_rsp_valid cyc=%0d got=%b exp=%b", c, bus.rsp0_valid_o, (c == 5)); end
      checks++; if (bus.busy_o !== (c <= 5)) begin failures++; $display("FAIL add_busy cyc=%0d got=%b exp=%b", c, bus.busy_o, (c <= 5)); end
      if (c >= 5) begin
        checks++; if (bus.rsp0_result_o !== 16'd12 || bus.rsp0_err_o !== 1'b0) begin
          failures++; $display("FAIL add_result cyc=%0d got=%0d err=%b exp=12 err=0", c, bus.rsp0_result_o, bus.rsp0_err_o); end
      end
    end
    $display("test_single_add done: req0 5+7");
  endtask

  task automatic test_round_robin();
    do_reset();
    mul_mode = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 3'd0; bus.req0_a_i = 8'd1; bus.req0_b_i = 8'd1;
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 3'd0; bus.req1_a_i = 8'd2; bus.req1_b_i = 8'd3;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) step();
      #1;
      checks++; if (bus.req0_ready_o !== (c % 12 == 0) || bus.req1_ready_o !== (c % 12 == 6)) begin
        failures++; $display("FAIL rr_ready cyc=%0d got=%b%b exp=%b%b", c, bus.req0_ready_o, bus.req1_ready_o, (c % 12 == 0), (c % 12 == 6)); end
      checks++; if (bus.rsp0_valid_o !== (c % 12 == 5) || bus.rsp1_valid_o !== (c % 12 == 11)) begin
        failures++; $display("FAIL rr_rsp_valid cyc=%0d got=%b%b exp=%b%b", c, bus.rsp0_valid_o, bus.rsp1_valid_o, (c % 12 == 5), (c % 12 == 11)); end
      if (c % 12 == 5) begin
        checks++; if (bus.rsp0_result_o !== 16'd2) begin failures++; $display("FAIL rr_rsp0 cyc=%0d got=%0d exp=2", c, bus.rsp0_result_o); end
      end
      if (c % 12 == 11) begin
        checks++; if (bus.rsp1_result_o !== 16'd5) begin failures++; $display("FAIL rr_rsp1 cyc=%0d got=%0d exp=5", c, bus.rsp1_result_o); end
      end
    end
    clear_inputs();
    $display("test_round_robin done: grants 0,1,0,1");
  endtask

  task automatic test_back_to_back();
    do_reset();
    mul_mode = 1'b1;
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 3'd2; bus.req1_a_i = 8'd3; bus.req1_b_i = 8'd4;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) step();
      #1;
      checks++; if (bus.req1_ready_o !== (c % 6 == 0) || bus.req0_ready_o !== 1'b0) begin
        failures++; $display("FAIL b2b_ready cyc=%0d got=%b%b exp=0%b", c, bus.req0_ready_o, bus.req1_ready_o, (c % 6 == 0)); end
      checks++; if (bus.rsp1_valid_o !== (c % 6 == 5)) begin
        failures++; $display("FAIL b2b_rsp_valid cyc=%0d got=%b exp=%b", c, bus.rsp1_valid_o, (c % 6 == 5)); end
      if (c % 6 == 5) begin
        checks++; if (bus.rsp1_result_o !== 16'd12 || bus.rsp1_err_o !== 1'b0) begin
          failures++; $display("FAIL b2b_result cyc=%0d got=%0d err=%b exp=12 err=0", c, bus.rsp1_result_o, bus.rsp1_err_o); end
      end
    end
    clear_inputs();
    mul_mode = 1'b0;
    $display("test_back_to_back done: req1 3*4 x3");
  endtask

  task automatic test_illegal_op();
    do_reset();
    mul_mode = 1'b0;
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 3'd7; bus.req1_a_i = 8'd9; bus.req1_b_i = 8'd9;
    #1;
    checks++; if (bus.req1_ready_o !== 1'b1) begin failures++; $display("FAIL ill_ready1 got=%b exp=1", bus.req1_ready_o); end
    step();
    bus.req1_valid_i = 1'b0;
    #1;
    checks++; if (bus.dsp_start_o !== 1'b0) begin failures++; $display("FAIL ill_no_start got=%b exp=0", bus.dsp_start_o); end
    checks++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_result_o !== 16'd0 || bus.rsp1_err_o !== 1'b1) begin
      failures++; $display("FAIL ill_rsp got v=%b r=%0d e=%b exp v=1 r=0 e=1", bus.rsp1_valid_o, bus.rsp1_result_o, bus.rsp1_err_o); end
    step();
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 3'd0; bus.req0_a_i = 8'd2; bus.req0_b_i = 8'd2;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1 || bus.rsp1_valid_o !== 1'b0) begin
      failures++; $display("FAIL ill_next_accept got ready0=%b rsp1v=%b exp 1,0", bus.req0_ready_o, bus.rsp1_valid_o); end
    step();
    bus.req0_valid_i = 1'b0;
    repeat (4) step();
    #1;
    checks++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_result_o !== 16'd4) begin
      failures++; $display("FAIL ill_after_rsp0 got v=%b r=%0d exp v=1 r=4", bus.rsp0_valid_o, bus.rsp0_result_o); end
    step();
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 3'd0; bus.req1_a_i = 8'd1; bus.req1_b_i = 8'd2;
    step();
    bus.req1_valid_i = 1'b0;
    repeat (4) step();
    #1;
    checks++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_result_o !== 16'd3 || bus.rsp1_err_o !== 1'b0) begin
      failures++; $display("FAIL ill_err_clears got v=%b r=%0d e=%b exp v=1 r=3 e=0", bus.rsp1_valid_o, bus.rsp1_result_o, bus.rsp1_err_o); end
    $display("test_illegal_op done: req1 op7");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    mul_mode = 1'b0;
    // Complete one op so the response registers are non-zero before reset.
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 3'd0; bus.req0_a_i = 8'd5; bus.req0_b_i = 8'd7;
    step();
    bus.req0_valid_i = 1'b0;
    repeat (5) step();
    // Cycle 6: second op from req0, reset lands in its WAIT phase (cycle 9).
    bus.req0_valid_i = 1'b1; bus.req0_a_i = 8'd9; bus.req0_b_i = 8'd1;
    step();
    bus.req0_valid_i = 1'b0;
    step();
    step();
    reset_i = 1'b1;
    step();
    #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.dsp_start_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_ctrl got busy=%b start=%b exp 0,0", bus.busy_o, bus.dsp_start_o); end
    checks++; if (bus.dsp_a_o !== 8'd0 || bus.dsp_b_o !== 8'd0) begin
      failures++; $display("FAIL rst_mid_dsp got a=%0d b=%0d exp 0,0", bus.dsp_a_o, bus.dsp_b_o); end
    checks++; if (bus.rsp0_result_o !== 16'd0 || bus.rsp0_valid_o !== 1'b0 || bus.rsp0_err_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_rsp0 got v=%b r=%0d e=%b exp 0", bus.rsp0_valid_o, bus.rsp0_result_o, bus.rsp0_err_o); end
    reset_i = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 3'd0; bus.req0_a_i = 8'd1; bus.req0_b_i = 8'd1;
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 3'd0; bus.req1_a_i = 8'd2; bus.req1_b_i = 8'd3;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_grant got %b%b exp 10", bus.req0_ready_o, bus.req1_ready_o); end
    step();
    clear_inputs();
    for (int c = 11; c <= 15; c++) begin
      if (c > 11) step();
      #1;
      checks++; if (bus.rsp0_valid_o !== (c == 15)) begin
        failures++; $display("FAIL rst_mid_rsp_valid cyc=%0d got=%b exp=%b", c, bus.rsp0_valid_o, (c == 15)); end
    end
    checks++; if (bus.rsp0_result_o !== 16'd2) begin failures++; $display("FAIL rst_mid_result got=%0d exp=2", bus.rsp0_result_o); end
    $display("test_reset_midflight done");
  endtask

  task automatic test_rsp_isolation();
    do_reset();
    mul_mode = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 3'd0; bus.req0_a_i = 8'd5; bus.req0_b_i = 8'd7;
    step();
    bus.req0_valid_i = 1'b0;
    repeat (5) step();
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 3'd0; bus.req1_a_i = 8'd4; bus.req1_b_i = 8'd5;
    for (int c = 6; c <= 12; c++) begin
      if (c > 6) begin
        step();
        bus.req1_valid_i = 1'b0;
      end
      #1;
      checks++; if (bus.rsp0_valid_o !== 1'b0 || bus.rsp0_result_o !== 16'd12 || bus.rsp0_err_o !== 1'b0) begin
        failures++; $display("FAIL iso_rsp0 cyc=%0d got v=%b r=%0d e=%b exp v=0 r=12 e=0", c, bus.rsp0_valid_o, bus.rsp0_result_o, bus.rsp0_err_o); end
      checks++; if (bus.rsp1_valid_o !== (c == 11)) begin
        failures++; $display("FAIL iso_rsp1_valid cyc=%0d got=%b exp=%b", c, bus.rsp1_valid_o, (c == 11)); end
    end
    checks++; if (bus.rsp1_result_o !== 16'd9) begin failures++; $display("FAIL iso_rsp1_result got=%0d exp=9", bus.rsp1_result_o); end
    $display("test_rsp_isolation done: rsp0=12 held, rsp1=9");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mul_mode = 1'b0;
    reset_i  = 1'b1;
    clear_inputs();
    test_reset();
    test_single_add();
    test_round_robin();
    test_back_to_back();
    test_illegal_op();
    test_reset_midflight();
    test_rsp_isolation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_share_arbiter.md
Name: dsp_share_arbiter

Overview:
- Shares one pipelined DSP arithmetic slice between two requesters, e.g. the switch/counter path and a future auto-test path.
- Arbitrates round-robin and accepts one operation through a valid/ready handshake.
- Drives the DSP operand and op inputs, waits the fixed DSP latency, then returns the registered result to the owning requester.
- Sits between the counter/mux logic and the external DSP result port, in the clk_100 domain.

Parameters:
DATA_WIDTH, 8, operand width (matches counter width)
RESULT_WIDTH, 16, DSP result width
OP_WIDTH, 3, operation code width
DSP_LATENCY, 3, cycles from the dsp_start_o cycle to a valid dsp_result_i; legal range 1 or more
NUM_OPS, 6, op codes 0..NUM_OPS-1 are legal; all others are illegal

Ports:
clk_i  in  1  clock (clk_100)
reset_i  in  1  synchronous, active-high reset
req0_valid_i  in  1  requester 0 has an op pending
req0_ready_o  out  1  requester 0 op accepted this cycle (when valid)
req0_op_i  in  OP_WIDTH  requester 0 op code
req0_a_i  in  DATA_WIDTH  requester 0 operand A
req0_b_i  in  DATA_WIDTH  requester 0 operand B
rsp0_valid_o  out  1  one-cycle pulse: requester 0 result ready
rsp0_result_o  out  RESULT_WIDTH  last result for requester 0
rsp0_err_o  out  1  last op for requester 0 was illegal
req1_* / rsp1_*  same as the requester 0 set, for requester 1
dsp_op_o  out  OP_WIDTH  op code to DSP
dsp_a_o  out  DATA_WIDTH  operand A to DSP
dsp_b_o  out  DATA_WIDTH  operand B to DSP
dsp_start_o  out  1  one-cycle launch strobe
dsp_result_i  in  RESULT_WIDTH  DSP result
busy_o  out  1  high whenever state is not IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset, applied on any clock edge where reset_i=1, from any state:
  - state returns to IDLE; any in-flight op is discarded and produces no response.
  - All outputs go to 0: dsp_a/b/op, dsp_start, rsp*_valid, rsp*_result, rsp*_err.
  - last_grant is set to 1, so requester 0 wins first.
- Arbitration, in IDLE only:
  - If exactly one requester has valid high, it gets the grant.
  - If both are valid, the grant goes to the requester that is not last_grant.
  - reqN_ready_o = (state==IDLE) and (grant==N). This is combinational; at most one ready is high at a time, and both are low outside IDLE.
- Transfer happens when valid and ready are both high in cycle A. Op, a and b are captured, owner and last_grant are set, and the next state depends on op:
  - Legal op (op < NUM_OPS): next state ISSUE.
  - Illegal op: next state RESP, with result 0 and err=1 for that transfer.
- Requesters hold valid and payload until accepted. Deasserting valid before acceptance is allowed and has no effect.
- ISSUE (cycle A+1):
  - dsp_a/b/op_o are registered from the captured op and are valid from this cycle.
  - dsp_start_o=1 for exactly this cycle.
  - Latency counter loads DSP_LATENCY; next state WAIT.
- WAIT: the counter decrements each cycle. In cycle A+1+DSP_LATENCY (counter reaches 1), dsp_result_i is captured with err=0, and the next state is RESP.
- dsp_a/b/op_o stay stable from ISSUE through WAIT and hold their last values afterwards.
- RESP (legal: A+2+DSP_LATENCY; illegal: A+1):
  - The owner's rspN_valid_o pulses high for one cycle.
  - The owner's rspN_result_o and rspN_err_o update in the same cycle and hold until that owner's next RESP.
  - The other requester's rsp outputs are untouched. Next state IDLE.
- Throughput:
  - Legal op: next accept no earlier than A+3+DSP_LATENCY.
  - Illegal op: next accept no earlier than A+2.
- dsp_result_i is ignored in every cycle other than the capture cycle.
- Op encoding passes through unchanged: 0 ADD, 1 SUBTR, 2 MUL, 3 ARTH_SHIFT_R, 4 SHIFT_L, 5 SHIFT_R.
- The block performs no arithmetic itself.

Test Plan:
1. DSP_LATENCY=3, DSP model returns a+b. req0 op=0 a=5 b=7 accepted at cycle 0 -> dsp_start_o high at cycle 1 only, dsp_a_o=5, dsp_b_o=7; rsp0_valid_o pulses at cycle 5 with result 12, err 0; busy_o is 0 from cycle 6.
2. Right after reset, req0 (a=1,b=1) and req1 (a=2,b=3) are both held valid -> req0 accepted at cycle 0 with rsp0=2 at cycle 5; req1 accepted at cycle 6 with rsp1=5 at cycle 11; grants then alternate 0,1,0,1.
3. req1 only, valid held continuously with op=2 a=3 b=4, DSP returns a*b -> accepts at cycles 0, 6, 12; each rsp1 = 12; req0_ready_o never high.
4. req1 op=7 -> accepted at cycle 0; no dsp_start_o; rsp1_valid_o at cycle 1 with result 0 and err 1; next accept possible at cycle 2.
5. req0 accepted at cycle 0, reset_i=1 at cycle 3 (WAIT) -> no rsp0_valid_o; all outputs 0 at cycle 4; after release with both valid, req0 is granted first.
6. rsp0 returns 12, then req1 completes with 9 -> rsp0_result_o stays 12 and rsp0_valid_o stays 0 throughout the req1 transaction.
